// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types.
//   word_t : 32-bit machine word used on every datapath and memory bus.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dcache_pkg.sv
// Data-cache package: FSM state encoding, the hit-counter dump address and
// address-field width helpers derived from the cache geometry.
// The CNTWR state exists only when DCACHE_HITCNT_EN is defined.
package dcache_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
`ifdef DCACHE_HITCNT_EN
    CNTWR,
`endif
    DONE
  } dstate_t;

  localparam word_t HITCNT_ADDR = 32'h0000_3100;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  // Everything above the index, block offset and 2-bit byte offset.
  function automatic int tag_w(input int sets, input int block_words);
    return 32 - $clog2(sets) - $clog2(block_words) - 2;
  endfunction
endpackage

// File: rtl/dcache_if.sv
// Datapath <-> dcache <-> memory-controller bus bundle.
//   Datapath side : halt, dmemREN, dmemWEN, dmemaddr, dmemstore -> cache
//                   dhit, dmemload, flushed                     <- cache
//   Memory side   : dREN, dWEN, daddr, dstore                   <- cache
//                   dload, dwait                                -> cache
// modport master : the cache itself.
// modport slave  : the environment (datapath + memory controller).
interface dcache_if;
  import cpu_types_pkg::*;

  logic  halt;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;
  logic  flushed;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;

  modport master (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport slave (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_lru.sv
// True-LRU age tracker, one age per way per set.
//   CLK, RST   : clock, asynchronous active-high reset (age of way w = w)
//   acc_en     : a hit is being serviced this cycle
//   acc_set    : set of the hit
//   acc_way    : way of the hit
//   query_set  : set whose LRU way is requested
//   victim_way : way with the oldest age (WAYS-1) in query_set
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     acc_en,
  input  logic [idx_w(SETS)-1:0]   acc_set,
  input  logic [way_w(WAYS)-1:0]   acc_way,
  input  logic [idx_w(SETS)-1:0]   query_set,
  output logic [way_w(WAYS)-1:0]   victim_way
);
  localparam int WW = way_w(WAYS);

  logic [WW-1:0] age [SETS][WAYS];

  // Ages stay a permutation of 0..WAYS-1: younger-than-accessed ways age by
  // one and the accessed way becomes the youngest.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WW'(w);
    end else if (acc_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == acc_way)
          age[acc_set][w] <= '0;
        else if (age[acc_set][w] < age[acc_set][acc_way])
          age[acc_set][w] <= age[acc_set][w] + WW'(1);
      end
    end
  end

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[query_set][w] == WW'(WAYS - 1))
        victim_way = WW'(w);
  end
endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate, N-way set-associative data cache, true LRU.
//   CLK, RST : clock, asynchronous active-high reset
//   dif      : dcache_if.master (datapath request/response + memory port)
// Hits complete in one cycle; misses write back a dirty victim (WB), then
// fill the line (FETCH) and retry. halt flushes every dirty line, then
// flushed stays high until reset.
// Optional feature macro: DCACHE_HITCNT_EN -- counts first-try hits and
// writes the count to HITCNT_ADDR after the flush (CNTWR state).
module dcache_assoc
  import cpu_types_pkg::*;
  import dcache_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic     CLK,
  input  logic     RST,
  dcache_if.master dif
);
  localparam int IW = idx_w(SETS);
  localparam int OW = off_w(BLOCK_WORDS);
  localparam int TW = tag_w(SETS, BLOCK_WORDS);
  localparam int WW = way_w(WAYS);

`ifdef DCACHE_HITCNT_EN
  localparam dstate_t FLUSH_END = CNTWR;
`else
  localparam dstate_t FLUSH_END = DONE;
`endif

  logic          valid [SETS][WAYS];
  logic          dirty [SETS][WAYS];
  logic [TW-1:0] tags  [SETS][WAYS];
  word_t         data  [SETS][WAYS][BLOCK_WORDS];

  dstate_t       state;
  logic [IW-1:0] v_set;
  logic [WW-1:0] v_way;
  logic [TW-1:0] v_tag;
  logic [OW-1:0] k;
  logic [IW-1:0] f_set;
  logic [WW-1:0] f_way;
`ifdef DCACHE_HITCNT_EN
  word_t         hitcnt;
  logic          retry;   // next IDLE hit is the retried access after a fill
`endif

  logic          req;
  logic [TW-1:0] rq_tag;
  logic [IW-1:0] rq_idx;
  logic [OW-1:0] rq_off;
  logic          unused_byte_off;
  logic          hit;
  logic [WW-1:0] hit_way;
  logic          inv_found;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] victim;
  logic          serve;
  logic          k_last;
  logic          line_dirty;
  logic          flush_adv;

  assign req             = dif.dmemREN | dif.dmemWEN;
  assign rq_tag          = dif.dmemaddr[31 -: TW];
  assign rq_idx          = dif.dmemaddr[2 + OW +: IW];
  assign rq_off          = dif.dmemaddr[2 +: OW];
  assign unused_byte_off = ^dif.dmemaddr[1:0];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[rq_idx][w] && tags[rq_idx][w] == rq_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[rq_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
  end

  assign victim = inv_found ? inv_way : lru_way;
  // halt outranks a pending request, so no hit is reported while halting.
  assign serve  = (state == IDLE) && !dif.halt && req && hit;

  dcache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .CLK        (CLK),
    .RST        (RST),
    .acc_en     (serve),
    .acc_set    (rq_idx),
    .acc_way    (hit_way),
    .query_set  (rq_idx),
    .victim_way (lru_way)
  );

  assign k_last     = (k == OW'(BLOCK_WORDS - 1));
  assign line_dirty = valid[f_set][f_way] & dirty[f_set][f_way];
  // Clean/invalid lines are skipped in a single cycle.
  assign flush_adv  = line_dirty ? (!dif.dwait && k_last) : 1'b1;

  // Memory-side outputs decode straight from registered state, so an
  // asynchronous reset drops dREN/dWEN in the same cycle.
  always_comb begin
    dif.dhit     = serve;
    dif.dmemload = serve ? data[rq_idx][hit_way][rq_off] : '0;
    dif.flushed  = 1'b0;
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = '0;
    dif.dstore   = '0;
    case (state)
      WB: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {tags[v_set][v_way], v_set, k, 2'b00};
        dif.dstore = data[v_set][v_way][k];
      end
      FETCH: begin
        dif.dREN  = 1'b1;
        dif.daddr = {v_tag, v_set, k, 2'b00};
      end
      FLUSH: begin
        if (line_dirty) begin
          dif.dWEN   = 1'b1;
          dif.daddr  = {tags[f_set][f_way], f_set, k, 2'b00};
          dif.dstore = data[f_set][f_way][k];
        end
      end
`ifdef DCACHE_HITCNT_EN
      CNTWR: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = HITCNT_ADDR;
        dif.dstore = hitcnt;
      end
`endif
      DONE:    dif.flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      v_set <= '0;
      v_way <= '0;
      v_tag <= '0;
      k     <= '0;
      f_set <= '0;
      f_way <= '0;
`ifdef DCACHE_HITCNT_EN
      hitcnt <= '0;
      retry  <= 1'b0;
`endif
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          tags[s][w]  <= '0;
          for (int b = 0; b < BLOCK_WORDS; b++)
            data[s][w][b] <= '0;
        end
    end else begin
      case (state)
        IDLE: begin
          if (dif.halt) begin
            state <= FLUSH;
            f_set <= '0;
            f_way <= '0;
            k     <= '0;
          end else if (req && hit) begin
            if (dif.dmemWEN) begin
              data[rq_idx][hit_way][rq_off] <= dif.dmemstore;
              dirty[rq_idx][hit_way]        <= 1'b1;
            end
`ifdef DCACHE_HITCNT_EN
            if (!retry)
              hitcnt <= hitcnt + 32'd1;
            retry <= 1'b0;
`endif
          end else if (req) begin
            v_set <= rq_idx;
            v_way <= victim;
            v_tag <= rq_tag;
            k     <= '0;
            state <= (valid[rq_idx][victim] && dirty[rq_idx][victim]) ? WB : FETCH;
          end
        end
        WB: begin
          if (!dif.dwait) begin
            if (k_last) begin
              k     <= '0;
              state <= FETCH;
            end else begin
              k <= k + OW'(1);
            end
          end
        end
        FETCH: begin
          if (!dif.dwait) begin
            data[v_set][v_way][k] <= dif.dload;
            if (k_last) begin
              valid[v_set][v_way] <= 1'b1;
              dirty[v_set][v_way] <= 1'b0;
              tags[v_set][v_way]  <= v_tag;
              k                   <= '0;
              state               <= IDLE;
`ifdef DCACHE_HITCNT_EN
              retry <= 1'b1;
`endif
            end else begin
              k <= k + OW'(1);
            end
          end
        end
        FLUSH: begin
          if (line_dirty && !dif.dwait && !k_last)
            k <= k + OW'(1);
          if (flush_adv) begin
            k <= '0;
            if (f_way == WW'(WAYS - 1)) begin
              f_way <= '0;
              if (f_set == IW'(SETS - 1))
                state <= FLUSH_END;
              else
                f_set <= f_set + IW'(1);
            end else begin
              f_way <= f_way + WW'(1);
            end
          end
        end
`ifdef DCACHE_HITCNT_EN
        CNTWR: begin
          if (!dif.dwait)
            state <= DONE;
        end
`endif
        DONE:    ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc (SETS=8, WAYS=2, BLOCK_WORDS=2).
// A memory responder with configurable latency serves the memory port and
// logs completed transfers; a behavioural cache model (per-set MRU lists,
// per-way contents, its own memory image) predicts hits, read data and the
// exact memory traffic of every access and of the final flush.
module tb_dcache_assoc;
  import cpu_types_pkg::*;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int BW   = 2;
  localparam int MEMW = 4096;

  logic CLK;
  logic RST;
  dcache_if dif ();

  dcache_assoc #(.SETS(SETS), .WAYS(WAYS), .BLOCK_WORDS(BW)) dut (
    .CLK (CLK),
    .RST (RST),
    .dif (dif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- memory responder ----------------
  word_t mem [MEMW];
  int    lat_lo = 1;
  int    lat_hi = 1;
  bit    busy;
  int    waits;
  bit    log_op [$];
  word_t log_a  [$];
  word_t log_d  [$];

  function automatic int widx(input word_t a);
    return int'((a >> 2) % MEMW);
  endfunction

  initial begin
    dif.dwait = 1'b1;
    dif.dload = '0;
    busy      = 1'b0;
    waits     = 0;
    forever begin
      @(negedge CLK);
      if (RST || !(dif.dREN || dif.dWEN)) begin
        dif.dwait = 1'b1;
        busy      = 1'b0;
      end else begin
        if (!busy) begin
          busy  = 1'b1;
          waits = int'($urandom_range(lat_hi, lat_lo));
        end
        if (waits > 0) begin
          dif.dwait = 1'b1;
          waits--;
        end else begin
          dif.dwait = 1'b0;
          busy      = 1'b0;
          if (dif.dWEN) begin
            mem[widx(dif.daddr)] = dif.dstore;
            log_op.push_back(1'b1); log_a.push_back(dif.daddr); log_d.push_back(dif.dstore);
          end else begin
            dif.dload = mem[widx(dif.daddr)];
            log_op.push_back(1'b0); log_a.push_back(dif.daddr); log_d.push_back('0);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit    m_valid [SETS][WAYS];
  bit    m_dirty [SETS][WAYS];
  word_t m_tag   [SETS][WAYS];
  word_t m_data  [SETS][WAYS][BW];
  int    m_order [SETS][WAYS];   // way ids, most recently used first
  int    m_hits;
  word_t ref_mem [MEMW];
  bit    exp_op [$];
  word_t exp_a  [$];
  word_t exp_d  [$];

  task automatic touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic model_access(input bit wr, input word_t a, input word_t wd,
                              output bit hit, output word_t rd);
    int    s    = int'((a / (4 * BW)) % SETS);
    int    off  = int'((a / 4) % BW);
    word_t t    = a / (4 * BW * SETS);
    int    w    = -1;
    word_t base;
    word_t va;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    hit = (w >= 0);
    if (!hit) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = m_order[s][WAYS-1];
      if (m_valid[s][w] && m_dirty[s][w])
        for (int b = 0; b < BW; b++) begin
          va = ((m_tag[s][w] * SETS + word_t'(s)) * BW + word_t'(b)) * 4;
          exp_op.push_back(1'b1); exp_a.push_back(va); exp_d.push_back(m_data[s][w][b]);
          ref_mem[widx(va)] = m_data[s][w][b];
        end
      base = (t * SETS + word_t'(s)) * BW * 4;
      for (int b = 0; b < BW; b++) begin
        exp_op.push_back(1'b0); exp_a.push_back(base + word_t'(4 * b)); exp_d.push_back('0);
        m_data[s][w][b] = ref_mem[widx(base + word_t'(4 * b))];
      end
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
    end else begin
      m_hits++;
    end
    touch(s, w);
    if (wr) begin
      m_data[s][w][off] = wd;
      m_dirty[s][w]     = 1'b1;
    end
    rd = m_data[s][w][off];
  endtask

  task automatic clear_logs();
    log_op.delete(); log_a.delete(); log_d.delete();
    exp_op.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_traffic(input string tag);
    check({tag, "_count"}, word_t'(log_a.size()), word_t'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
      check({tag, "_op"},   word_t'(log_op[i]), word_t'(exp_op[i]));
      check({tag, "_addr"}, log_a[i], exp_a[i]);
      check({tag, "_data"}, log_d[i], exp_d[i]);
    end
  endtask

  task automatic do_reset();
    RST           = 1'b1;
    dif.halt      = 1'b0;
    dif.dmemREN   = 1'b0;
    dif.dmemWEN   = 1'b0;
    dif.dmemaddr  = '0;
    dif.dmemstore = '0;
    for (int i = 0; i < MEMW; i++) begin
      mem[i]     = word_t'(i) * 32'd4 - 32'h60;
      ref_mem[i] = word_t'(i) * 32'd4 - 32'h60;
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_order[s][w] = w;
        for (int b = 0; b < BW; b++) m_data[s][w][b] = '0;
      end
    m_hits = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    clear_logs();
  endtask

  // One datapath request, held until dhit; checked against the model.
  task automatic access(input bit wr, input word_t a, input word_t wd,
                        output bit first_try, output word_t rd);
    bit    exp_hit;
    word_t exp_rd;
    bit    seen = 1'b0;
    int    cyc;
    clear_logs();
    model_access(wr, a, wd, exp_hit, exp_rd);
    @(posedge CLK);
    #1;
    dif.dmemREN   = !wr;
    dif.dmemWEN   = wr;
    dif.dmemaddr  = a;
    dif.dmemstore = wd;
    rd            = '0;
    for (cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (dif.dhit) begin
        seen = 1'b1;
        rd   = dif.dmemload;
        break;
      end
      @(posedge CLK);
      #1;
    end
    first_try = seen && (cyc == 0);
    @(posedge CLK);
    #1;
    dif.dmemREN = 1'b0;
    dif.dmemWEN = 1'b0;
    check("dhit_seen", word_t'(seen), 32'd1);
    check("first_try_hit", word_t'(first_try), word_t'(exp_hit));
    if (!wr) check("read_data", rd, exp_rd);
    check_traffic("mem");
  endtask

  task automatic do_flush(input string tag);
    bit seen = 1'b0;
    clear_logs();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w])
          for (int b = 0; b < BW; b++) begin
            exp_op.push_back(1'b1);
            exp_a.push_back(((m_tag[s][w] * SETS + word_t'(s)) * BW + word_t'(b)) * 4);
            exp_d.push_back(m_data[s][w][b]);
          end
`ifdef DCACHE_HITCNT_EN
    exp_op.push_back(1'b1); exp_a.push_back(32'h0000_3100); exp_d.push_back(word_t'(m_hits));
`endif
    @(posedge CLK);
    #1 dif.halt = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      if (dif.flushed) begin seen = 1'b1; break; end
      @(posedge CLK);
      #1;
    end
    check({tag, "_flushed"}, word_t'(seen), 32'd1);
    check_traffic(tag);
    repeat (3) @(posedge CLK);
    #1 dif.halt = 1'b0;
    @(posedge CLK);
    #2;
    check({tag, "_flushed_hold"}, word_t'(dif.flushed), 32'd1);
    check({tag, "_done_dwen"}, word_t'(dif.dWEN), 32'd0);
    check({tag, "_done_dren"}, word_t'(dif.dREN), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dhit"},     word_t'(dif.dhit),    32'd0);
    check({tag, "_dmemload"}, dif.dmemload,         32'd0);
    check({tag, "_flushed"},  word_t'(dif.flushed), 32'd0);
    check({tag, "_dREN"},     word_t'(dif.dREN),    32'd0);
    check({tag, "_dWEN"},     word_t'(dif.dWEN),    32'd0);
    check({tag, "_daddr"},    dif.daddr,            32'd0);
    check({tag, "_dstore"},   dif.dstore,           32'd0);
  endtask

  bit    ft;
  word_t rd;
  bit    seen_wb1;
  int    nwr;

  initial begin
    RST           = 1'b1;
    dif.halt      = 1'b0;
    dif.dmemREN   = 1'b0;
    dif.dmemWEN   = 1'b0;
    dif.dmemaddr  = '0;
    dif.dmemstore = '0;
    #1;
    check_outputs_zero("reset");

    // Directed: cold fill, hits, write hit, dirty eviction.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    access(1'b0, 32'h100, '0, ft, rd);
    check("cold_read_data", rd, 32'hA0);
    access(1'b0, 32'h104, '0, ft, rd);
    check("reread_hit", word_t'(ft), 32'd1);
    check("reread_data", rd, 32'hA4);
    access(1'b1, 32'h100, 32'hDEAD, ft, rd);
    check("write_hit", word_t'(ft), 32'd1);
    access(1'b0, 32'h100, '0, ft, rd);
    check("read_after_write", rd, 32'hDEAD);
    access(1'b0, 32'h200, '0, ft, rd);
    access(1'b0, 32'h200, '0, ft, rd);
    access(1'b0, 32'h300, '0, ft, rd);
    check("evict_wb_word0_addr", log_a.size() > 0 ? log_a[0] : 32'hFFFF_FFFF, 32'h100);
    check("evict_wb_word0_data", log_d.size() > 0 ? log_d[0] : 32'hFFFF_FFFF, 32'hDEAD);

    // Reset in the middle of a writeback.
    do_reset();
    access(1'b1, 32'h100, 32'h1234_5678, ft, rd);
    access(1'b0, 32'h200, '0, ft, rd);
    @(posedge CLK);
    #1;
    dif.dmemREN  = 1'b1;
    dif.dmemaddr = 32'h300;
    seen_wb1     = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge CLK);
      #2;
      if (dif.dWEN && dif.daddr == 32'h104) begin seen_wb1 = 1'b1; break; end
    end
    check("wb_word1_reached", word_t'(seen_wb1), 32'd1);
    RST = 1'b1;
    #1;
    check_outputs_zero("abort");
    do_reset();
    access(1'b0, 32'h300, '0, ft, rd);
    check("after_abort_miss", word_t'(ft), 32'd0);

    // Two dirty lines, then halt.
    do_reset();
    access(1'b1, 32'h100, 32'hAAAA_0001, ft, rd);
    access(1'b1, 32'h20C, 32'hBBBB_0002, ft, rd);
    do_flush("flush2");
    nwr = 0;
    foreach (log_op[i]) if (log_op[i]) nwr++;
`ifdef DCACHE_HITCNT_EN
    check("flush2_writes", word_t'(nwr), 32'd5);
`else
    check("flush2_writes", word_t'(nwr), 32'd4);
`endif

    // Random traffic with random memory latency, then a full flush.
    do_reset();
    lat_lo = 0; lat_hi = 2;
    for (int n = 0; n < 300; n++)
      access(1'($urandom_range(1, 0)), word_t'($urandom_range(255, 0)) << 2, $urandom(), ft, rd);
    do_flush("flush_rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache with true-LRU replacement.
- Sits between the datapath's data-memory port and the memory controller's dcache port.
- Single-cycle hits; multi-word block fill and writeback on a miss.
- On halt, flushes every dirty line to memory, then raises flushed.

Parameters:
- SETS, 8: number of sets; power of two, at least 2.
- WAYS, 2: associativity; power of two, at least 2.
- BLOCK_WORDS, 2: 32-bit words per line; power of two, at least 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- halt  in  1  datapath halt request; starts a flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request.
- dmemaddr  in  32  byte address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- dhit  out  1  request satisfied this cycle.
- dmemload  out  32  read data, valid when dhit is high.
- flushed  out  1  flush complete; held high until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data.
- dwait  in  1  memory busy; a transfer completes in the cycle dwait is low.

Behaviour:
- Address fields, MSB to LSB: tag, index (log2 SETS bits), block offset (log2 BLOCK_WORDS bits), byte offset (2 bits).
- Reset: every output is 0, all lines are invalid and clean, data is 0, and LRU age of way w is w. FSM enters IDLE.
- Reset asserted mid-transaction aborts it immediately; dREN and dWEN drop in the same cycle.
- If dmemREN and dmemWEN are both high, the request is treated as a write.
- IDLE:
  - Hit means a valid way whose tag matches.
  - On a hit, dhit=1 combinationally in the same cycle.
  - Read hit: dmemload = the addressed word.
  - Write hit: the word, dirty=1 and the LRU update are written at the clock edge.
  - Halt has priority over a pending request: halt=1 goes to FLUSH.
  - Miss with a dirty victim goes to WB; miss with a clean victim goes to FETCH.
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1. The victim is latched on entry to WB or FETCH.
- LRU update on every hit: ways with age below the accessed way's age increment; the accessed way's age becomes 0.
- WB:
  - Words k=0..BLOCK_WORDS-1 are sent in order.
  - dWEN=1, daddr = {victim tag, index, k, 2'b00}, dstore = victim word k.
  - k advances only when dwait=0. After the last word, go to FETCH.
- FETCH:
  - Words k=0..BLOCK_WORDS-1 are read in order with dREN=1, daddr = {request tag, index, k, 2'b00}.
  - dload is written into the victim way when dwait=0.
  - After the last word: valid=1, dirty=0, tag updated, return to IDLE. The retried request then hits.
- dhit is never asserted in WB or FETCH.
- FLUSH:
  - Walks set-major, then way, then word.
  - Valid dirty lines: each word is written as in WB, advancing on dwait=0.
  - Clean or invalid lines are skipped at one cycle per line.
  - After the last line, go to DONE.
- DONE: flushed=1 with no memory requests. Exits only on reset.
- A request arriving during WB, FETCH or FLUSH is held by the datapath; the cache does not sample it.

Optional Feature:
- Macro: DCACHE_HITCNT_EN.
- Enabled:
  - A 32-bit hit counter increments on each first-try hit in IDLE. The retried access after a fill is not counted.
  - After FLUSH, a CNTWR state writes the count to address 32'h0000_3100 (dWEN=1, dstore=count), holding until dwait=0, then goes to DONE.
- Disabled: no counter and no CNTWR state; FLUSH goes straight to DONE.

Decomposition:
- Package dcache_pkg holds:
  - the FSM state enum;
  - HITCNT_ADDR;
  - address-field width functions derived from the parameters.
- word_t comes from cpu_types_pkg.
- One sub-module, dcache_lru: per-set age arrays with inputs access valid, set and way, and output victim way for a queried set.

Test Plan:
- Cold read 0x100, memory returns 0xA0/0xA4 with dwait low 2 cycles per word -> 2 fetches at 0x100/0x104, then dhit with dmemload=0xA0. A re-read of 0x104 hits in 1 cycle with 0xA4.
- Write 0xDEAD to 0x100 after the fill -> single-cycle dhit, no memory traffic. Reading 0x100 returns 0xDEAD.
- SETS=8, WAYS=2: fill tags for 0x100 and 0x200, write 0x100, touch 0x200, then read 0x300 -> the 0x100 line is written back (0xDEAD at 0x100) before fetching 0x300.
- Two dirty lines, then halt -> exactly their 4 words are written in set/way/word order, then flushed=1 stays high.
- Assert RST during WB word 1 -> dWEN=0 at once, all outputs 0, next read of the same address misses.
- With DCACHE_HITCNT_EN and 3 first-try hits -> after the flush, 0x3100 is written with 3.
